// File: rtl/branch_cond_if.sv
// Request/result handshake bundle for branch_cond_unit.
// The master side issues requests and takes results; the slave side is the unit.
interface branch_cond_if #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] rddata;
    logic [WIDTH-1:0] rsdata;
    logic [WIDTH-1:0] ndata;
    logic [4:0]       cond;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic             out_jump;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, rddata, rsdata, ndata, cond, in_tag, out_ready,
        input  in_ready, out_valid, out_jump, out_tag
    );

    modport slave (
        input  in_valid, rddata, rsdata, ndata, cond, in_tag, out_ready,
        output in_ready, out_valid, out_jump, out_tag
    );
endinterface

// File: rtl/branch_cond_unit.sv
// Two-stage branch condition evaluator with a loop counter.
// S1 captures the accepted request (operand B already selected, LOOP decision
// already taken against loop_cnt); S2 holds the resolved jump and its tag.
module branch_cond_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_cond_if.slave     bus,
    input  logic             flush,
    input  logic             cnt_load,
    input  logic [CNT_W-1:0] cnt_value,
    output logic [CNT_W-1:0] loop_cnt
);

    typedef enum logic [2:0] {
        OP_EQ   = 3'b000,
        OP_NE   = 3'b001,
        OP_GT   = 3'b010,
        OP_LT   = 3'b011,
        OP_ZERO = 3'b100,
        OP_NEG  = 3'b101,
        OP_ONES = 3'b110,
        OP_LOOP = 3'b111
    } op_e;

    // Stage 1 state
    logic             s1_valid;
    logic [WIDTH-1:0] s1_rd;
    logic [WIDTH-1:0] s1_b;
    logic             s1_signed;
    op_e              s1_op;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_loop_jump;

    // Stage 2 state
    logic             s2_valid;

    logic             s2_free;
    logic             accept;
    op_e              in_op;
    logic             in_is_loop;
    logic             loop_jump_now;
    logic             s2_jump_d;

    assign in_op         = op_e'(bus.cond[2:0]);
    assign in_is_loop    = (in_op == OP_LOOP);
    // A LOOP jumps only if the counter stays non-zero after its decrement.
    assign loop_jump_now = (loop_cnt != '0) && (loop_cnt != CNT_W'(1));

    // S2 can take new data when empty or when its result leaves this cycle.
    assign s2_free      = !s2_valid || bus.out_ready;
    assign bus.in_ready = !flush && (!s1_valid || s2_free);
    assign accept       = bus.in_valid && bus.in_ready;
    assign bus.out_valid = s2_valid;

    // Resolve the condition from the registered S1 operands.
    always_comb begin
        // NOTE: default first so every path assigns s2_jump_d and no latch is inferred.
        s2_jump_d = 1'b0;
        case (s1_op)
            OP_EQ:   s2_jump_d = (s1_rd == s1_b);
            OP_NE:   s2_jump_d = (s1_rd != s1_b);
            OP_GT:   s2_jump_d = s1_signed ? ($signed(s1_rd) > $signed(s1_b)) : (s1_rd > s1_b);
            OP_LT:   s2_jump_d = s1_signed ? ($signed(s1_rd) < $signed(s1_b)) : (s1_rd < s1_b);
            OP_ZERO: s2_jump_d = (s1_rd == '0);
            OP_NEG:  s2_jump_d = s1_rd[WIDTH-1];
            OP_ONES: s2_jump_d = (s1_rd == '1);
            OP_LOOP: s2_jump_d = s1_loop_jump;
            default: s2_jump_d = 1'b0;
        endcase
    end

    // Stage 1: capture accepted requests, empty when the entry moves to S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            s1_valid     <= 1'b0;
            s1_rd        <= '0;
            s1_b         <= '0;
            s1_signed    <= 1'b0;
            s1_op        <= OP_EQ;
            s1_tag       <= '0;
            s1_loop_jump <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else if (accept) begin
            s1_valid     <= 1'b1;
            s1_rd        <= bus.rddata;
            s1_b         <= bus.cond[3] ? bus.ndata : bus.rsdata;
            s1_signed    <= bus.cond[4];
            s1_op        <= in_op;
            s1_tag       <= bus.in_tag;
            s1_loop_jump <= loop_jump_now;
        end else if (s2_free) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: registered result, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid     <= 1'b0;
            bus.out_jump <= 1'b0;
            bus.out_tag  <= '0;
        end else if (flush) begin
            s2_valid     <= 1'b0;
            bus.out_jump <= 1'b0;
            bus.out_tag  <= '0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_jump <= s2_jump_d;
                bus.out_tag  <= s1_tag;
            end
        end
    end

    // Loop counter: a load wins over a LOOP decrement; flush blocks acceptance
    // so it never decrements, and earlier decrements stay taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loop_cnt <= '0;
        end else if (cnt_load) begin
            loop_cnt <= cnt_value;
        end else if (accept && in_is_loop && (loop_cnt != '0)) begin
            loop_cnt <= loop_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed bench for branch_cond_unit: compares, LOOP counting, backpressure,
// flush and asynchronous reset, with hand-computed expectations.
module tb_branch_cond_unit;

    localparam int WIDTH = 16;
    localparam int CNT_W = 16;
    localparam int TAG_W = 4;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             cnt_load;
    logic [CNT_W-1:0] cnt_value;
    logic [CNT_W-1:0] loop_cnt;

    int n_vec;
    int n_err;

    branch_cond_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    branch_cond_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W), .TAG_W(TAG_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .flush    (flush),
        .cnt_load (cnt_load),
        .cnt_value(cnt_value),
        .loop_cnt (loop_cnt)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] rd, input logic [15:0] rs, input logic [15:0] n,
                         input logic [4:0] cnd, input logic [3:0] tag);
        bus.in_valid = 1'b1;
        bus.rddata   = rd;
        bus.rsdata   = rs;
        bus.ndata    = n;
        bus.cond     = cnd;
        bus.in_tag   = tag;
    endtask

    // One isolated request with out_ready=1; checks result two edges after accept.
    task automatic send_one(input string name, input logic [15:0] rd, input logic [15:0] rs,
                            input logic [15:0] n, input logic [4:0] cnd,
                            input logic [3:0] tag, input logic exp_jump);
        drive(rd, rs, n, cnd, tag);
        #1;
        chk({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        chk({name, "_s1_only"}, 64'(bus.out_valid), 64'd0);
        step();
        chk({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({name, "_jump"}, 64'(bus.out_jump), 64'(exp_jump));
        chk({name, "_tag"}, 64'(bus.out_tag), 64'(tag));
        step();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        cnt_load = 1'b0;
        cnt_value = '0;
        bus.in_valid = 1'b0;
        bus.rddata = '0;
        bus.rsdata = '0;
        bus.ndata = '0;
        bus.cond = '0;
        bus.in_tag = '0;
        bus.out_ready = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_jump", 64'(bus.out_jump), 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
        chk("rst_loop_cnt", 64'(loop_cnt), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        step();

        // Unsigned vs signed LT, back-to-back
        drive(16'h8000, 16'h0001, 16'h0000, 5'b00011, 4'd1);
        step();
        drive(16'h8000, 16'h0001, 16'h0000, 5'b10011, 4'd2);
        chk("b2b_a_not_yet", 64'(bus.out_valid), 64'd0);
        step();
        bus.in_valid = 1'b0;
        chk("b2b_a_valid", 64'(bus.out_valid), 64'd1);
        chk("b2b_a_jump", 64'(bus.out_jump), 64'd0);
        chk("b2b_a_tag", 64'(bus.out_tag), 64'd1);
        step();
        chk("b2b_b_valid", 64'(bus.out_valid), 64'd1);
        chk("b2b_b_jump", 64'(bus.out_jump), 64'd1);
        chk("b2b_b_tag", 64'(bus.out_tag), 64'd2);
        step();
        chk("b2b_drained", 64'(bus.out_valid), 64'd0);

        // Condition codes
        send_one("eq_imm",    16'h0005, 16'h1234, 16'h0005, 5'b01000, 4'd3, 1'b1);
        send_one("ne_rs",     16'h0005, 16'h0005, 16'h0007, 5'b00001, 4'd4, 1'b0);
        send_one("gt_uns",    16'hFFFF, 16'h0001, 16'h0000, 5'b00010, 4'd5, 1'b1);
        send_one("gt_sgn",    16'hFFFF, 16'h0001, 16'h0000, 5'b10010, 4'd6, 1'b0);
        send_one("zero_junk", 16'h0000, 16'h0009, 16'h0009, 5'b11100, 4'd7, 1'b1);
        send_one("neg_set",   16'h8001, 16'h0000, 16'h0000, 5'b01101, 4'd8, 1'b1);
        send_one("neg_clr",   16'h7FFF, 16'h0000, 16'h0000, 5'b01101, 4'd9, 1'b0);
        send_one("ones",      16'hFFFF, 16'h0000, 16'h0000, 5'b10110, 4'd10, 1'b1);
        send_one("lt_imm",    16'h0003, 16'hFFFF, 16'h0002, 5'b01011, 4'd11, 1'b0);

        // Loop counter: load 3, then four LOOPs
        cnt_load = 1'b1;
        cnt_value = 16'd3;
        step();
        cnt_load = 1'b0;
        chk("loop_load", 64'(loop_cnt), 64'd3);
        drive(16'hAAAA, 16'h5555, 16'h1111, 5'b11111, 4'd4);
        step();
        chk("loop1_cnt", 64'(loop_cnt), 64'd2);
        bus.in_tag = 4'd5;
        step();
        chk("loop2_cnt", 64'(loop_cnt), 64'd1);
        chk("loop1_jump", 64'(bus.out_jump), 64'd1);
        chk("loop1_tag", 64'(bus.out_tag), 64'd4);
        bus.in_tag = 4'd6;
        step();
        chk("loop3_cnt", 64'(loop_cnt), 64'd0);
        chk("loop2_jump", 64'(bus.out_jump), 64'd1);
        chk("loop2_tag", 64'(bus.out_tag), 64'd5);
        bus.in_tag = 4'd7;
        step();
        bus.in_valid = 1'b0;
        chk("loop4_cnt", 64'(loop_cnt), 64'd0);
        chk("loop3_jump", 64'(bus.out_jump), 64'd0);
        chk("loop3_tag", 64'(bus.out_tag), 64'd6);
        step();
        chk("loop4_stay0", 64'(loop_cnt), 64'd0);
        chk("loop4_valid", 64'(bus.out_valid), 64'd1);
        chk("loop4_jump", 64'(bus.out_jump), 64'd0);
        chk("loop4_tag", 64'(bus.out_tag), 64'd7);
        step();

        // LOOP together with load: jump from pre-load count (0), load wins
        drive(16'h0000, 16'h0000, 16'h0000, 5'b00111, 4'd8);
        cnt_load = 1'b1;
        cnt_value = 16'd5;
        step();
        bus.in_valid = 1'b0;
        cnt_load = 1'b0;
        chk("ldloop_cnt", 64'(loop_cnt), 64'd5);
        step();
        chk("ldloop_valid", 64'(bus.out_valid), 64'd1);
        chk("ldloop_jump", 64'(bus.out_jump), 64'd0);
        chk("ldloop_tag", 64'(bus.out_tag), 64'd8);
        step();

        // Backpressure: three requests with out_ready=0
        bus.out_ready = 1'b0;
        drive(16'h0001, 16'h0001, 16'h0000, 5'b00000, 4'd1);
        #1;
        chk("bp_ready_a", 64'(bus.in_ready), 64'd1);
        step();
        drive(16'h0001, 16'h0001, 16'h0000, 5'b00001, 4'd2);
        #1;
        chk("bp_ready_b", 64'(bus.in_ready), 64'd1);
        step();
        drive(16'h0000, 16'h0000, 16'h0000, 5'b00100, 4'd3);
        #1;
        chk("bp_ready_c_blocked", 64'(bus.in_ready), 64'd0);
        chk("bp_a_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_a_jump", 64'(bus.out_jump), 64'd1);
        chk("bp_a_tag", 64'(bus.out_tag), 64'd1);
        step();
        chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_hold_jump", 64'(bus.out_jump), 64'd1);
        chk("bp_hold_tag", 64'(bus.out_tag), 64'd1);
        chk("bp_hold_ready", 64'(bus.in_ready), 64'd0);
        step();
        chk("bp_hold2_tag", 64'(bus.out_tag), 64'd1);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        chk("bp_b_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_b_jump", 64'(bus.out_jump), 64'd0);
        chk("bp_b_tag", 64'(bus.out_tag), 64'd2);
        step();
        chk("bp_c_valid", 64'(bus.out_valid), 64'd1);
        chk("bp_c_jump", 64'(bus.out_jump), 64'd1);
        chk("bp_c_tag", 64'(bus.out_tag), 64'd3);
        step();
        chk("bp_drained", 64'(bus.out_valid), 64'd0);

        // Flush with both stages full (second request is a LOOP: 5 -> 4)
        bus.out_ready = 1'b0;
        drive(16'h0000, 16'h0000, 16'h0000, 5'b00100, 4'd9);
        step();
        drive(16'h0000, 16'h0000, 16'h0000, 5'b00111, 4'd10);
        step();
        chk("fl_pre_cnt", 64'(loop_cnt), 64'd4);
        chk("fl_pre_valid", 64'(bus.out_valid), 64'd1);
        flush = 1'b1;
        #1;
        chk("fl_in_ready", 64'(bus.in_ready), 64'd0);
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_valid", 64'(bus.out_valid), 64'd0);
        chk("fl_jump", 64'(bus.out_jump), 64'd0);
        chk("fl_tag", 64'(bus.out_tag), 64'd0);
        chk("fl_cnt", 64'(loop_cnt), 64'd4);
        step();
        chk("fl_s1_killed", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;

        // Asynchronous reset mid-operation with a pending result
        bus.out_ready = 1'b0;
        drive(16'h0007, 16'h0007, 16'h0000, 5'b00000, 4'd12);
        step();
        bus.in_valid = 1'b0;
        step();
        chk("ar_pending", 64'(bus.out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(bus.out_valid), 64'd0);
        chk("ar_cnt", 64'(loop_cnt), 64'd0);
        chk("ar_tag", 64'(bus.out_tag), 64'd0);
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("ar_in_ready", 64'(bus.in_ready), 64'd1);
        step();
        step();
        chk("ar_no_output", 64'(bus.out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/branch_cond_unit.md
BRANCH_COND_UNIT -- requirements
Module: branch_cond_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning loop-counter width in bits.
REQ-003 The block SHALL have parameter TAG_W, default 4, meaning width of the pass-through request tag.
REQ-004 The block SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have port in_valid  in  1  request present.
REQ-007 The block SHALL have port in_ready  out  1  request accepted when in_valid && in_ready at a clk edge.
REQ-008 The block SHALL have ports rddata, rsdata, ndata  in  WIDTH each  operands rd, rs and immediate N.
REQ-009 The block SHALL have port cond  in  5  condition code.
REQ-010 The block SHALL have port in_tag  in  TAG_W  request tag.
REQ-011 The block SHALL have ports cnt_load  in  1  and cnt_value  in  CNT_W  for a loop-counter load.
REQ-012 The block SHALL have port flush  in  1  kills all in-flight requests.
REQ-013 The block SHALL have ports out_valid  out  1 / out_ready  in  1  result handshake.
REQ-014 The block SHALL have ports out_jump  out  1  and out_tag  out  TAG_W  branch decision and the tag of its request.
REQ-015 The block SHALL have port loop_cnt  out  CNT_W  current loop-counter value.

Function
REQ-016 The block SHALL decode cond as follows: cond[4] = 1 selects signed two's-complement compare; cond[3] selects B = ndata (1) or B = rsdata (0); cond[2:0] selects 000 EQ, 001 NE, 010 GT, 011 LT, 100 rd==0, 101 rd[WIDTH-1]==1, 110 rd==all-ones, 111 LOOP.
REQ-017 Codes 100/101/110 SHALL ignore cond[4:3]; LOOP SHALL ignore cond[4:3] and all operands.
REQ-018 GT/LT SHALL compare rddata against B unsigned when cond[4]=0 and signed when cond[4]=1 (e.g. WIDTH=16, 0xFFFF LT 0x0001: unsigned 0, signed 1).
REQ-019 The block SHALL be a 2-stage pipeline: S1 registers the accepted request; S2 registers out_jump and out_tag; out_valid SHALL rise on the second edge after acceptance.
REQ-020 in_ready SHALL be combinational: !flush && (!s1_valid || !s2_valid || out_ready).
REQ-021 S2 SHALL hold out_valid, out_jump and out_tag stable while out_valid && !out_ready.
REQ-022 With out_ready held at 1, the block SHALL accept one request per cycle and deliver results in order.
REQ-023 LOOP SHALL act on loop_cnt at the acceptance edge: if loop_cnt==0, jump=0 and loop_cnt stays 0; otherwise loop_cnt <= loop_cnt-1 and jump = (loop_cnt-1 != 0).
REQ-024 cnt_load=1 SHALL write cnt_value to loop_cnt on that edge, taking priority over a LOOP decrement in the same cycle.
REQ-025 A LOOP accepted in the same cycle as cnt_load SHALL compute its jump from the pre-load loop_cnt.
REQ-026 flush=1 SHALL clear s1_valid and s2_valid on the edge and accept no request that cycle.
REQ-027 flush SHALL NOT alter loop_cnt, except that cnt_load in the same cycle still applies.
REQ-028 Decrements already taken by flushed LOOP requests SHALL NOT be restored.
REQ-029 out_jump and out_tag SHALL be don't-care when out_valid=0; the implementation drives them to 0 on flush.

Reset
REQ-030 While rst_n=0 the block SHALL asynchronously force s1_valid=0, s2_valid=0, out_valid=0, out_jump=0, out_tag=0 and loop_cnt=0.
REQ-031 in_ready SHALL be 1 in the first cycle after reset release if flush=0.
REQ-032 A reset asserted mid-operation SHALL discard all in-flight requests with no output handshake.

Verification
REQ-033 The bench SHALL cover: WIDTH=16, rd=0x8000, rs=0x0001, cond=00011 then 10011 back-to-back, out_ready=1 -> out_jump 0 then 1 on consecutive cycles, each 2 cycles after its accept.
REQ-034 The bench SHALL cover: rd=0x0005, N=0x0005, cond=01000, tag=3 -> out_jump=1, out_tag=3.
REQ-035 The bench SHALL cover: cnt_load with cnt_value=3, then three LOOP requests -> out_jump 1,1,0; loop_cnt 2,1,0; a fourth LOOP -> jump 0 with loop_cnt staying 0.
REQ-036 The bench SHALL cover: three requests with out_ready=0 -> in_ready drops after two accepts; out_valid/out_jump/out_tag held stable; raising out_ready drains results in order.
REQ-037 The bench SHALL cover: flush with both stages full -> out_valid=0 next cycle, in_ready=0 during the flush cycle, loop_cnt unchanged.
REQ-038 The bench SHALL cover: rst_n pulsed low between clk edges with a pending result -> out_valid and loop_cnt become 0 immediately, without waiting for a clock edge.
